design_1_self_output_wrapper: RTL and testbench

BERT self-output layer engine: out = LayerNormLite(requant(A × W) + R), all int8, operands and result in byte-addressed external memory.
- Computes one token row at a time through a single-outstanding byte-wide memory master port.
- Sits between the host (which loads A, W, R and pulses start) and the memory/NoC fabric.
- Host reads the output back after done.

---
 rtl/design_1_self_output_wrapper_if.sv | 22 ++
 rtl/design_1_self_output_wrapper.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_design_1_self_output_wrapper.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/design_1_self_output_wrapper_if.sv
// Byte-wide memory master bus: one request at a time, read data returned
// on a later-or-same-cycle rvalid, writes complete on grant.
interface design_1_self_output_wrapper_if;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;
    logic        mem_err;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err
    );
endinterface

// File: rtl/design_1_self_output_wrapper.sv
// BERT self-output engine: O = LayerNormLite(requant(A x W) + R), int8.
// One token row at a time; every operand byte is fetched through a single
// outstanding byte-wide memory master.
module design_1_self_output_wrapper #(
    parameter int TOKENS = 32,
    parameter int EMBED  = 768
) (
    input  logic        clk,
    input  logic        rstn_pl,
    input  logic        start,
    output logic        done,
    output logic        error,
    input  logic [63:0] addr_attn_output,
    input  logic [63:0] addr_weight,
    input  logic [63:0] addr_residual,
    input  logic [63:0] addr_output,
    input  logic [31:0] requant_m_mm,
    input  logic [7:0]  requant_e_mm,
    input  logic [31:0] requant_m_ln,
    input  logic [7:0]  requant_e_ln,
    design_1_self_output_wrapper_if.master mem
);
    localparam int NW = (EMBED > 1) ? $clog2(EMBED) : 1;
    localparam int TW = (TOKENS > 1) ? $clog2(TOKENS) : 1;
    localparam int RECIP = ((1 << 24) + EMBED / 2) / EMBED;
    localparam logic signed [63:0] RECIP_S = 64'(RECIP);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_A, S_RD_W, S_ACC, S_RD_R, S_STORE,
        S_MEAN, S_NORM, S_WR, S_DONE, S_ERR
    } state_e;

    typedef enum logic [1:0] {B_IDLE, B_REQ, B_WAIT} bus_e;

    // sat8(((x * m) + rnd) >>> e), m zero-extended, 72-bit intermediate
    function automatic logic signed [7:0] requant(
        input logic signed [31:0] x,
        input logic [31:0]        m,
        input logic [5:0]         e
    );
        logic signed [71:0] xs, ms, prod, rnd, res;
        xs   = {{40{x[31]}}, x};
        ms   = {40'd0, m};
        prod = xs * ms;
        rnd  = '0;
        if (e != 6'd0) rnd = 72'sd1 <<< (e - 6'd1);
        res = (prod + rnd) >>> e;
        if (res > 72'sd127)       requant = 8'sd127;
        else if (res < -72'sd128) requant = -8'sd128;
        else                      requant = res[7:0];
    endfunction

    state_e state_q, state_d;
    bus_e   bus_q, bus_d;

    logic        req_q, req_d, we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        done_q, done_d, err_q, err_d;

    logic [63:0] a_base_q, a_base_d, w_base_q, w_base_d;
    logic [63:0] r_base_q, r_base_d, o_base_q, o_base_d;
    logic [31:0] m_mm_q, m_mm_d, m_ln_q, m_ln_d;
    logic [5:0]  e_mm_q, e_mm_d, e_ln_q, e_ln_d;

    logic [TW-1:0] t_q, t_d;
    logic [NW-1:0] n_q, n_d, k_q, k_d;

    logic signed [7:0]  a_q, a_d, w_q, w_d, r_q, r_d;
    logic signed [31:0] acc_q, acc_d, sum_q, sum_d, mu_q, mu_d;
    logic [7:0]         out_q, out_d;

    logic [9:0] row_q [EMBED];
    logic       row_we;
    logic [9:0] row_wdata, row_rd;

    logic               xfer_done, last_k, last_n, last_t;
    logic [63:0]        bus_addr;
    logic signed [7:0]  mm;
    logic [9:0]         s_val;
    logic signed [15:0] prod16;
    logic signed [31:0] diff;
    logic signed [63:0] sum64;

    assign xfer_done = (bus_q == B_REQ && mem.mem_gnt && (we_q || mem.mem_rvalid)) ||
                       (bus_q == B_WAIT && mem.mem_rvalid);
    assign last_k = (k_q == NW'(EMBED - 1));
    assign last_n = (n_q == NW'(EMBED - 1));
    assign last_t = (t_q == TW'(TOKENS - 1));
    assign row_rd = row_q[n_q];

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign done  = done_q;
    assign error = err_q;

    // State and datapath registers, async active-low reset
    always_ff @(posedge clk or negedge rstn_pl) begin
        if (!rstn_pl) begin
            state_q  <= S_IDLE;
            bus_q    <= B_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            a_base_q <= '0;
            w_base_q <= '0;
            r_base_q <= '0;
            o_base_q <= '0;
            m_mm_q   <= '0;
            m_ln_q   <= '0;
            e_mm_q   <= '0;
            e_ln_q   <= '0;
            t_q      <= '0;
            n_q      <= '0;
            k_q      <= '0;
            a_q      <= '0;
            w_q      <= '0;
            r_q      <= '0;
            acc_q    <= '0;
            sum_q    <= '0;
            mu_q     <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            bus_q    <= bus_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
            a_base_q <= a_base_d;
            w_base_q <= w_base_d;
            r_base_q <= r_base_d;
            o_base_q <= o_base_d;
            m_mm_q   <= m_mm_d;
            m_ln_q   <= m_ln_d;
            e_mm_q   <= e_mm_d;
            e_ln_q   <= e_ln_d;
            t_q      <= t_d;
            n_q      <= n_d;
            k_q      <= k_d;
            a_q      <= a_d;
            w_q      <= w_d;
            r_q      <= r_d;
            acc_q    <= acc_d;
            sum_q    <= sum_d;
            mu_q     <= mu_d;
            out_q    <= out_d;
        end
    end

    // Row buffer of residual-added values s[n]; plain storage, no reset
    always_ff @(posedge clk) begin
        if (row_we) row_q[n_q] <= row_wdata;
    end

    // Next-state: MAC over k, residual/store per n, then mean and normalize/write per n
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start) state_d = S_RD_A;
            S_RD_A:  if (xfer_done) state_d = mem.mem_err ? S_ERR : S_RD_W;
            S_RD_W:  if (xfer_done) state_d = mem.mem_err ? S_ERR : S_ACC;
            S_ACC:   state_d = last_k ? S_RD_R : S_RD_A;
            S_RD_R:  if (xfer_done) state_d = mem.mem_err ? S_ERR : S_STORE;
            S_STORE: state_d = last_n ? S_MEAN : S_RD_A;
            S_MEAN:  state_d = S_NORM;
            S_NORM:  state_d = S_WR;
            S_WR: begin
                if (xfer_done) begin
                    if (mem.mem_err) state_d = S_ERR;
                    else if (!last_n) state_d = S_NORM;
                    else state_d = last_t ? S_DONE : S_RD_A;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Byte address of the transaction the current bus state issues
    always_comb begin
        bus_addr = '0;
        case (state_q)
            S_RD_A:  bus_addr = a_base_q + 64'(t_q) * 64'(EMBED) + 64'(k_q);
            S_RD_W:  bus_addr = w_base_q + 64'(k_q) * 64'(EMBED) + 64'(n_q);
            S_RD_R:  bus_addr = r_base_q + 64'(t_q) * 64'(EMBED) + 64'(n_q);
            S_WR:    bus_addr = o_base_q + 64'(t_q) * 64'(EMBED) + 64'(n_q);
            default: bus_addr = '0;
        endcase
    end

    // Outputs and datapath: bus handshake, config capture, MAC, store, mean, normalize
    always_comb begin
        bus_d    = bus_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        done_d   = done_q;
        err_d    = err_q;
        a_base_d = a_base_q;
        w_base_d = w_base_q;
        r_base_d = r_base_q;
        o_base_d = o_base_q;
        m_mm_d   = m_mm_q;
        m_ln_d   = m_ln_q;
        e_mm_d   = e_mm_q;
        e_ln_d   = e_ln_q;
        t_d      = t_q;
        n_d      = n_q;
        k_d      = k_q;
        a_d      = a_q;
        w_d      = w_q;
        r_d      = r_q;
        acc_d    = acc_q;
        sum_d    = sum_q;
        mu_d     = mu_q;
        out_d    = out_q;
        row_we    = 1'b0;
        row_wdata = '0;
        mm     = '0;
        s_val  = '0;
        prod16 = '0;
        diff   = '0;
        sum64  = '0;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    a_base_d = addr_attn_output;
                    w_base_d = addr_weight;
                    r_base_d = addr_residual;
                    o_base_d = addr_output;
                    m_mm_d   = requant_m_mm;
                    m_ln_d   = requant_m_ln;
                    // shifts beyond 63 are out of range; pin them at 63
                    e_mm_d   = (requant_e_mm > 8'd63) ? 6'd63 : requant_e_mm[5:0];
                    e_ln_d   = (requant_e_ln > 8'd63) ? 6'd63 : requant_e_ln[5:0];
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    t_d      = '0;
                    n_d      = '0;
                    k_d      = '0;
                    acc_d    = '0;
                    sum_d    = '0;
                    bus_d    = B_IDLE;
                    req_d    = 1'b0;
                end
            end
            S_RD_A, S_RD_W, S_RD_R, S_WR: begin
                case (bus_q)
                    B_IDLE: begin
                        req_d   = 1'b1;
                        we_d    = (state_q == S_WR);
                        addr_d  = bus_addr;
                        wdata_d = (state_q == S_WR) ? out_q : 8'd0;
                        bus_d   = B_REQ;
                    end
                    B_REQ: begin
                        if (mem.mem_gnt) begin
                            req_d = 1'b0;
                            bus_d = (we_q || mem.mem_rvalid) ? B_IDLE : B_WAIT;
                        end
                    end
                    B_WAIT:  if (mem.mem_rvalid) bus_d = B_IDLE;
                    default: bus_d = B_IDLE;
                endcase
                if (xfer_done) begin
                    if (mem.mem_err) begin
                        err_d = 1'b1;
                    end else begin
                        case (state_q)
                            S_RD_A: a_d = mem.mem_rdata;
                            S_RD_W: w_d = mem.mem_rdata;
                            S_RD_R: r_d = mem.mem_rdata;
                            default: begin
                                if (!last_n) begin
                                    n_d = n_q + 1'b1;
                                end else begin
                                    n_d = '0;
                                    if (last_t) begin
                                        done_d = 1'b1;
                                    end else begin
                                        t_d   = t_q + 1'b1;
                                        sum_d = '0;
                                    end
                                end
                            end
                        endcase
                    end
                end
            end
            S_ACC: begin
                prod16 = a_q * w_q;
                acc_d  = acc_q + {{16{prod16[15]}}, prod16};
                k_d    = last_k ? '0 : k_q + 1'b1;
            end
            S_STORE: begin
                mm        = requant(acc_q, m_mm_q, e_mm_q);
                s_val     = {{2{mm[7]}}, mm} + {{2{r_q[7]}}, r_q};
                row_we    = 1'b1;
                row_wdata = s_val;
                sum_d     = sum_q + {{22{s_val[9]}}, s_val};
                acc_d     = '0;
                n_d       = last_n ? '0 : n_q + 1'b1;
            end
            S_MEAN: begin
                // floor(sum * RECIP / 2^24) approximates sum / EMBED
                sum64 = {{32{sum_q[31]}}, sum_q};
                mu_d  = 32'((sum64 * RECIP_S) >>> 24);
            end
            S_NORM: begin
                diff  = {{22{row_rd[9]}}, row_rd} - mu_q;
                out_d = requant(diff, m_ln_q, e_ln_q);
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_design_1_self_output_wrapper.sv
// Directed bench with a byte memory responder and a write scoreboard.
module tb_design_1_self_output_wrapper;
    localparam int TK = 2;
    localparam int EM = 4;
    localparam longint RCP = ((longint'(1) << 24) + EM / 2) / EM;
    localparam logic [63:0] A_B = 64'h0800;
    localparam logic [63:0] W_B = 64'h1000;
    localparam logic [63:0] R_B = 64'h2000;
    localparam logic [63:0] O_B = 64'h3000;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk = 1'b0, rstn_pl = 1'b0, start = 1'b0;
    logic done, error;
    logic [63:0] addr_o = O_B;
    logic [31:0] m_mm = 32'd256, m_ln = 32'd256;
    logic [7:0]  e_mm = 8'd8, e_ln = 8'd8;

    logic [7:0] mem [0:16383];
    wr_t sbq[$];
    int checks = 0, passes = 0, fails = 0;
    int gmax = 0, lmin = 0, lmax = 0, gcnt = 0, lat = 0, rdcnt = 0, err_idx = -1;
    int stab_viol = 0, ost_viol = 0;
    bit pend = 0, prev_wait = 0, rd_err = 0;
    logic [63:0] rd_addr, s_addr;
    logic s_we;
    logic [7:0] s_wd;

    logic [7:0] t1_exp [4] = '{8'hFF, 8'h00, 8'h01, 8'h02};
    logic [7:0] ln_exp [4] = '{8'hFA, 8'hFE, 8'h02, 8'h06};
    logic [7:0] st_exp [4] = '{8'h80, 8'h80, 8'h7F, 8'h7F};

    design_1_self_output_wrapper_if mif();

    design_1_self_output_wrapper #(.TOKENS(TK), .EMBED(EM)) dut (
        .clk(clk), .rstn_pl(rstn_pl), .start(start), .done(done), .error(error),
        .addr_attn_output(A_B), .addr_weight(W_B), .addr_residual(R_B), .addr_output(addr_o),
        .requant_m_mm(m_mm), .requant_e_mm(e_mm), .requant_m_ln(m_ln), .requant_e_ln(e_ln),
        .mem(mif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rd(input longint a);
        logic [63:0] av;
        av = 64'(a);
        return mem[av[13:0]];
    endfunction

    function automatic longint sx8(input logic [7:0] b);
        return longint'($signed(b));
    endfunction

    function automatic longint rq(input longint x, input longint m, input int e);
        longint v;
        v = x * m;
        if (e > 0) v = v + (longint'(1) << (e - 1));
        v = v >>> e;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v;
    endfunction

    // Expected output bytes from the bench's own copy of A, W, R
    task automatic build_expect();
        longint s [EM];
        longint acc, sum, mu;
        sbq.delete();
        for (int t = 0; t < TK; t++) begin
            sum = 0;
            for (int n = 0; n < EM; n++) begin
                acc = 0;
                for (int k = 0; k < EM; k++)
                    acc += sx8(rd(A_B + t * EM + k)) * sx8(rd(W_B + k * EM + n));
                s[n] = rq(acc, m_mm, e_mm) + sx8(rd(R_B + t * EM + n));
                sum += s[n];
            end
            mu = (sum * RCP) >>> 24;
            for (int n = 0; n < EM; n++)
                sbq.push_back('{addr: O_B + 64'(t * EM + n), data: 8'(rq(s[n] - mu, m_ln, e_ln))});
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    endtask

    task automatic pulse_start();
        rdcnt = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int c;
        c = 0;
        while (!(done || error) && c < 5000) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_finished"}, 64'(done || error), 64'd1);
    endtask

    task automatic run(input string tag);
        build_expect();
        pulse_start();
        chk({tag, "_done_clr"}, 64'(done), 64'd0);
        chk({tag, "_err_clr"}, 64'(error), 64'd0);
        wait_end(tag);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_sb_empty"}, 64'(sbq.size()), 64'd0);
    endtask

    task automatic fill_t1();
        clear_mem();
        mem[A_B[13:0] + 0] = 8'd1;  mem[A_B[13:0] + 1] = 8'd2;
        mem[A_B[13:0] + 2] = 8'd3;  mem[A_B[13:0] + 3] = 8'd4;
        mem[A_B[13:0] + 4] = 8'hFB; mem[A_B[13:0] + 5] = 8'd7;
        mem[A_B[13:0] + 6] = 8'd0;  mem[A_B[13:0] + 7] = 8'd100;
        for (int k = 0; k < EM; k++) mem[W_B[13:0] + 14'(k * EM + k)] = 8'd1;
    endtask

    task automatic fill_rand();
        clear_mem();
        for (int i = 0; i < TK * EM; i++) begin
            mem[A_B[13:0] + 14'(i)] = 8'($urandom_range(255, 0));
            mem[R_B[13:0] + 14'(i)] = 8'($urandom_range(255, 0));
        end
        for (int i = 0; i < EM * EM; i++) mem[W_B[13:0] + 14'(i)] = 8'($urandom_range(255, 0));
    endtask

    // Memory responder: grant delay, read latency, error injection, bus rule monitors
    initial begin
        wr_t e;
        mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = 8'h00; mif.mem_err = 1'b0;
        forever begin
            @(negedge clk);
            mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_err = 1'b0;
            if (!rstn_pl) begin
                pend = 0; prev_wait = 0;
                continue;
            end
            if (mif.mem_req && pend) ost_viol++;
            if (prev_wait && mif.mem_req &&
                (mif.mem_addr !== s_addr || mif.mem_we !== s_we || mif.mem_wdata !== s_wd)) stab_viol++;
            prev_wait = 0;
            if (pend) begin
                if (lat <= 1) begin
                    mif.mem_rvalid = 1'b1; mif.mem_rdata = rd(longint'(rd_addr)); mif.mem_err = rd_err;
                    pend = 0;
                end else lat--;
            end
            if (mif.mem_req) begin
                if (gcnt == 0) begin
                    mif.mem_gnt = 1'b1;
                    gcnt = $urandom_range(gmax, 0);
                    if (mif.mem_we) begin
                        mem[mif.mem_addr[13:0]] = mif.mem_wdata;
                        chk("wr_expected", 64'(sbq.size() != 0), 64'd1);
                        if (sbq.size() != 0) begin
                            e = sbq.pop_front();
                            chk("wr_addr", mif.mem_addr, e.addr);
                            chk("wr_data", 64'(mif.mem_wdata), 64'(e.data));
                        end
                    end else begin
                        rdcnt++;
                        rd_addr = mif.mem_addr;
                        rd_err = (rdcnt == err_idx);
                        lat = $urandom_range(lmax, lmin);
                        if (lat == 0) begin
                            mif.mem_rvalid = 1'b1; mif.mem_rdata = rd(longint'(rd_addr)); mif.mem_err = rd_err;
                        end else pend = 1;
                    end
                end else begin
                    gcnt--;
                    prev_wait = 1;
                    s_addr = mif.mem_addr; s_we = mif.mem_we; s_wd = mif.mem_wdata;
                end
            end
        end
    end

    initial begin
        clear_mem();
        repeat (3) @(negedge clk);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_req", 64'(mif.mem_req), 64'd0);
        chk("rst_we", 64'(mif.mem_we), 64'd0);
        chk("rst_addr", mif.mem_addr, 64'd0);
        chk("rst_wdata", 64'(mif.mem_wdata), 64'd0);
        rstn_pl = 1'b1;

        // identity weights, row0 mean 2
        fill_t1();
        run("t1");
        for (int n = 0; n < EM; n++) chk("t1_row0", 64'(mem[O_B[13:0] + 14'(n)]), 64'(t1_exp[n]));

        // matmul saturates at 127, s constant 129, outputs all zero
        clear_mem();
        for (int i = 0; i < TK * EM; i++) begin
            mem[A_B[13:0] + 14'(i)] = 8'd127; mem[R_B[13:0] + 14'(i)] = 8'd2;
        end
        for (int i = 0; i < EM * EM; i++) mem[W_B[13:0] + 14'(i)] = 8'd127;
        run("t2");
        for (int i = 0; i < TK * EM; i++) chk("t2_zero", 64'(mem[O_B[13:0] + 14'(i)]), 64'd0);

        // residual-only rows, norm scale x2 then saturating scale
        clear_mem();
        mem[R_B[13:0] + 0] = 8'hFD; mem[R_B[13:0] + 1] = 8'hFF;
        mem[R_B[13:0] + 2] = 8'h01; mem[R_B[13:0] + 3] = 8'h03;
        mem[R_B[13:0] + 4] = 8'd10; mem[R_B[13:0] + 5] = 8'hEC;
        mem[R_B[13:0] + 6] = 8'd30; mem[R_B[13:0] + 7] = 8'hD8;
        m_ln = 32'd512;
        run("t3");
        for (int n = 0; n < EM; n++) chk("t3_row0", 64'(mem[O_B[13:0] + 14'(n)]), 64'(ln_exp[n]));
        m_ln = 32'h0010_0000;
        run("t3s");
        for (int n = 0; n < EM; n++) chk("t3s_row0", 64'(mem[O_B[13:0] + 14'(n)]), 64'(st_exp[n]));

        // M_mm=0 kills the matmul, E_ln=0 means no rounding term
        fill_rand();
        m_mm = 32'd0; e_mm = 8'd8; m_ln = 32'd1; e_ln = 8'd0;
        run("t4");

        // read error mid-row, then clean rerun
        m_mm = 32'd256; e_mm = 8'd8; m_ln = 32'd256; e_ln = 8'd8;
        fill_t1();
        err_idx = 5;
        build_expect();
        pulse_start();
        wait_end("t5");
        chk("t5_error", 64'(error), 64'd1);
        chk("t5_done", 64'(done), 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk("t5_req_low", 64'(mif.mem_req), 64'd0);
            @(negedge clk);
        end
        err_idx = -1;
        run("t5_rerun");

        // same random job with zero latency then random grant/rvalid latency
        fill_rand();
        m_mm = 32'd3; e_mm = 8'd7; m_ln = 32'd200; e_ln = 8'd6;
        run("t6_fast");
        gmax = 5; lmin = 1; lmax = 8;
        run("t6_slow");
        gmax = 0; lmin = 0; lmax = 0;

        // start while busy must not retarget the output
        fill_t1();
        m_mm = 32'd256; e_mm = 8'd8; m_ln = 32'd256; e_ln = 8'd8;
        build_expect();
        pulse_start();
        repeat (20) @(negedge clk);
        addr_o = 64'h3800;
        start = 1'b1; @(negedge clk); start = 1'b0;
        addr_o = O_B;
        wait_end("t7");
        chk("t7_done", 64'(done), 64'd1);
        chk("t7_sb_empty", 64'(sbq.size()), 64'd0);

        // async reset mid-row, then full rerun
        build_expect();
        pulse_start();
        repeat (25) @(negedge clk);
        @(posedge clk);
        #2 rstn_pl = 1'b0;
        #1;
        chk("t8_req", 64'(mif.mem_req), 64'd0);
        chk("t8_we", 64'(mif.mem_we), 64'd0);
        chk("t8_addr", mif.mem_addr, 64'd0);
        chk("t8_wdata", 64'(mif.mem_wdata), 64'd0);
        chk("t8_done", 64'(done), 64'd0);
        chk("t8_error", 64'(error), 64'd0);
        @(negedge clk); rstn_pl = 1'b1;
        run("t8_after");
        for (int n = 0; n < EM; n++) chk("t8_row0", 64'(mem[O_B[13:0] + 14'(n)]), 64'(t1_exp[n]));

        chk("addr_stable", 64'(stab_viol), 64'd0);
        chk("one_outstanding", 64'(ost_viol), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
